// File: rtl/rtc_mc_pkg.sv
// rtl/rtc_mc_pkg.sv - register map and field positions shared by the rtc_mc files
package rtc_mc_pkg;

  typedef enum logic [4:0] {
    RTC_MC_CTRL   = 5'd0,
    RTC_MC_CNT    = 5'd1,
    RTC_MC_PERIOD = 5'd2,
    RTC_MC_PRESC  = 5'd3,
    RTC_MC_STATUS = 5'd4,
    RTC_MC_INTEN  = 5'd5,
    RTC_MC_CMP0   = 5'd8,
    RTC_MC_CMP1   = 5'd9,
    RTC_MC_CMP2   = 5'd10,
    RTC_MC_CMP3   = 5'd11
  } rtc_mc_reg_e;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int STATUS_OVF_LSB   = 0;
  localparam int STATUS_CMP_LSB   = 16;
  localparam int INTEN_OVF_BIT    = 0;
  localparam int INTEN_CMP_LSB    = 16;

  function automatic logic [4:0] cmp_off(input int n);
    return 5'(int'(RTC_MC_CMP0) + n);
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtl/rtc_prescaler.sv - divides clk by presc+1 and emits a one-clock tick
module rtc_prescaler
  import rtc_mc_pkg::*;
#(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] pcnt;

  // clr comes from a CNT write, which must also swallow this cycle's tick
  assign tick = en && !clr && (pcnt == presc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt == presc) ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_mc.sv
// rtl/rtc_mc.sv - prescaled multi-channel RTC/timer with compare channels and
// a saturating overflow counter on the IO bus
module rtc_mc
  import rtc_mc_pkg::*;
#(
  parameter int ADDRESS           = 0,
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int CNT_SIZE          = 16,
  parameter int PRESC_WIDTH       = 8,
  parameter int CHANNELS          = 2,
  parameter int PERIOD_STATIC     = 0,
  parameter int OVF_CNT_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr_w,
  input  logic                         rd_w,
  input  logic [31:0]                  bus_in,
  output logic [31:0]                  bus_out,
  output logic                         req_bus,
  output logic                         intr,
  input  logic                         int_rst
);

  localparam logic [BUS_ADDR_DATA_LEN:0] BASE  = (BUS_ADDR_DATA_LEN+1)'(ADDRESS);
  localparam logic [BUS_ADDR_DATA_LEN:0] LIMIT = (BUS_ADDR_DATA_LEN+1)'(ADDRESS + 32);

  logic [4:0]               off;
  logic                     wr, rd, cnt_wr;
  logic                     en, oneshot;
  logic [CNT_SIZE-1:0]      cnt, period, period_m1;
  logic [PRESC_WIDTH-1:0]   presc;
  logic                     ovf_ie;
  logic [CHANNELS-1:0]      cmp_ie, cmpf, cmp_hit;
  logic [CNT_SIZE-1:0]      cmp [CHANNELS];
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt;
  logic                     int_rst_q;
  logic                     tick, wrap, ovf_evt, clr_flags;
  logic                     unused_bus;

  assign req_bus    = ({1'b0, addr} >= BASE) && ({1'b0, addr} < LIMIT);
  assign off        = addr[4:0];
  assign wr         = req_bus && wr_w;
  assign rd         = req_bus && rd_w && !wr_w;
  assign cnt_wr     = wr && (off == RTC_MC_CNT);
  assign unused_bus = ^bus_in;

  rtc_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (en && (period != '0)),
    .clr   (cnt_wr),
    .presc (presc),
    .tick  (tick)
  );

  assign period_m1 = period - 1'b1;
  assign wrap      = cnt >= period_m1;
  assign ovf_evt   = tick && wrap;
  assign clr_flags = (rd && (off == RTC_MC_STATUS)) || (int_rst && !int_rst_q);

  always_comb begin
    cmp_hit = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      cmp_hit[n] = tick && (cnt == cmp[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en        <= 1'b0;
      oneshot   <= 1'b0;
      cnt       <= '0;
      period    <= CNT_SIZE'(PERIOD_STATIC);
      presc     <= '0;
      ovf_ie    <= 1'b0;
      cmp_ie    <= '0;
      cmpf      <= '0;
      ovf_cnt   <= '0;
      int_rst_q <= 1'b0;
      intr      <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) cmp[n] <= '0;
    end else begin
      int_rst_q <= int_rst;
      intr      <= (ovf_ie && (ovf_cnt != '0)) || |(cmpf & cmp_ie);

      if (cnt_wr) cnt <= bus_in[CNT_SIZE-1:0];
      else if (tick) cnt <= wrap ? '0 : cnt + 1'b1;

      if (wr && (off == RTC_MC_CTRL)) begin
        en      <= bus_in[CTRL_EN_BIT];
        oneshot <= bus_in[CTRL_ONESHOT_BIT];
      end else if (ovf_evt && oneshot) begin
        en <= 1'b0;
      end

      if (wr && (off == RTC_MC_PERIOD)) period <= bus_in[CNT_SIZE-1:0];
      if (wr && (off == RTC_MC_PRESC))  presc  <= bus_in[PRESC_WIDTH-1:0];
      if (wr && (off == RTC_MC_INTEN)) begin
        ovf_ie <= bus_in[INTEN_OVF_BIT];
        cmp_ie <= bus_in[INTEN_CMP_LSB +: CHANNELS];
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr && (off == cmp_off(n))) cmp[n] <= bus_in[CNT_SIZE-1:0];
      end

      // an event in the clearing cycle survives the clear
      cmpf <= (clr_flags ? '0 : cmpf) | cmp_hit;
      if (clr_flags) ovf_cnt <= OVF_CNT_WIDTH'(ovf_evt);
      else if (ovf_evt && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  always_comb begin
    bus_out = '0;
    if (req_bus) begin
      case (off)
        RTC_MC_CTRL: begin
          bus_out[CTRL_EN_BIT]      = en;
          bus_out[CTRL_ONESHOT_BIT] = oneshot;
        end
        RTC_MC_CNT:    bus_out[CNT_SIZE-1:0]    = cnt;
        RTC_MC_PERIOD: bus_out[CNT_SIZE-1:0]    = period;
        RTC_MC_PRESC:  bus_out[PRESC_WIDTH-1:0] = presc;
        RTC_MC_STATUS: begin
          bus_out[STATUS_OVF_LSB +: OVF_CNT_WIDTH] = ovf_cnt;
          bus_out[STATUS_CMP_LSB +: CHANNELS]      = cmpf;
        end
        RTC_MC_INTEN: begin
          bus_out[INTEN_OVF_BIT]            = ovf_ie;
          bus_out[INTEN_CMP_LSB +: CHANNELS] = cmp_ie;
        end
        default: begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (off == cmp_off(n)) bus_out[CNT_SIZE-1:0] = cmp[n];
          end
        end
      endcase
    end
  end

endmodule
